// File: rtl/block_device_requester.sv
// Block-device requester: turns one client command into one device request,
// streams the sector data in the matching direction and reports completion.
module block_device_requester #(
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned SECTOR_BITS = 32,
  parameter int unsigned TAG_BITS    = 1,
  parameter int unsigned BEAT_BITS   = 6
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [SECTOR_BITS-1:0] cmd_offset,
  input  logic [SECTOR_BITS-1:0] cmd_len,
  input  logic [TAG_BITS-1:0]    cmd_tag,

  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [DATA_BITS-1:0]   wdata_bits,

  output logic                   rdata_valid,
  input  logic                   rdata_ready,
  output logic [DATA_BITS-1:0]   rdata_bits,

  output logic                   done_valid,
  output logic [TAG_BITS-1:0]    done_tag,
  output logic                   done_error,
  output logic                   busy,

  output logic                   bdev_req_valid,
  input  logic                   bdev_req_ready,
  output logic                   bdev_req_bits_write,
  output logic [SECTOR_BITS-1:0] bdev_req_bits_offset,
  output logic [SECTOR_BITS-1:0] bdev_req_bits_len,
  output logic [TAG_BITS-1:0]    bdev_req_bits_tag,

  output logic                   bdev_data_valid,
  input  logic                   bdev_data_ready,
  output logic [DATA_BITS-1:0]   bdev_data_bits_data,
  output logic [TAG_BITS-1:0]    bdev_data_bits_tag,

  input  logic                   bdev_resp_valid,
  output logic                   bdev_resp_ready,
  input  logic [DATA_BITS-1:0]   bdev_resp_bits_data,
  input  logic [TAG_BITS-1:0]    bdev_resp_bits_tag,

  input  logic [SECTOR_BITS-1:0] bdev_info_nsectors
);

  localparam int unsigned CntBits = SECTOR_BITS + BEAT_BITS;

  typedef enum logic [2:0] {
    StIdle, StCheck, StReq, StWdata, StWresp, StRdata, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [SECTOR_BITS-1:0] offset_q, offset_d;
  logic [SECTOR_BITS-1:0] len_q, len_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [CntBits-1:0]     cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [SECTOR_BITS:0]   end_sector;
  logic                   data_fire, resp_fire, tag_bad;

  // One extra bit so offset+len cannot wrap past the capacity check.
  assign end_sector = {1'b0, offset_q} + {1'b0, len_q};
  assign data_fire  = bdev_data_valid && bdev_data_ready;
  assign resp_fire  = bdev_resp_valid && bdev_resp_ready;
  assign tag_bad    = (bdev_resp_bits_tag != tag_q);

  assign bdev_req_bits_write  = write_q;
  assign bdev_req_bits_offset = offset_q;
  assign bdev_req_bits_len    = len_q;
  assign bdev_req_bits_tag    = tag_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      offset_q <= '0;
      len_q    <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    offset_d = offset_q;
    len_d    = len_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          write_d  = cmd_write;
          offset_d = cmd_offset;
          len_d    = cmd_len;
          tag_d    = cmd_tag;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (len_q == '0) begin
          state_d = StDone;
        end else if (end_sector > {1'b0, bdev_info_nsectors}) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bdev_req_ready) begin
          cnt_d   = {len_q, {BEAT_BITS{1'b0}}};
          state_d = write_q ? StWdata : StRdata;
        end
      end
      StWdata: begin
        if (data_fire) begin
          cnt_d = cnt_q - CntBits'(1);
          if (cnt_q == CntBits'(1)) state_d = StWresp;
        end
      end
      StWresp: begin
        if (resp_fire) begin
          if (tag_bad) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StRdata: begin
        if (resp_fire) begin
          if (tag_bad) err_d = 1'b1;
          cnt_d = cnt_q - CntBits'(1);
          if (cnt_q == CntBits'(1)) state_d = StDone;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready           = 1'b0;
    bdev_req_valid      = 1'b0;
    bdev_data_valid     = 1'b0;
    wdata_ready         = 1'b0;
    bdev_data_bits_data = '0;
    bdev_data_bits_tag  = '0;
    bdev_resp_ready     = 1'b0;
    rdata_valid         = 1'b0;
    rdata_bits          = '0;
    done_valid          = 1'b0;
    done_tag            = '0;
    done_error          = 1'b0;
    busy                = (state_q != StIdle);
    unique case (state_q)
      // Held low while reset is asserted so no command is taken during reset.
      StIdle:  cmd_ready = reset;
      StReq:   bdev_req_valid = 1'b1;
      StWdata: begin
        bdev_data_valid     = wdata_valid;
        wdata_ready         = bdev_data_ready;
        bdev_data_bits_data = wdata_bits;
        bdev_data_bits_tag  = tag_q;
      end
      StWresp: bdev_resp_ready = 1'b1;
      StRdata: begin
        rdata_valid     = bdev_resp_valid;
        bdev_resp_ready = rdata_ready;
        rdata_bits      = bdev_resp_bits_data;
      end
      StDone: begin
        done_valid = 1'b1;
        done_tag   = tag_q;
        done_error = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_device_requester.sv
// Bench for block_device_requester: a cycle-stepped client and device model with
// random backpressure, checked against expectations computed from the command rules.
module tb_block_device_requester;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 32;
  localparam int unsigned TW = 1;
  localparam int unsigned BB = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [SW-1:0] cmd_offset, cmd_len;
  logic [TW-1:0] cmd_tag;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata_bits;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata_bits;
  logic          done_valid, done_error, busy;
  logic [TW-1:0] done_tag;
  logic          bdev_req_valid, bdev_req_ready, bdev_req_bits_write;
  logic [SW-1:0] bdev_req_bits_offset, bdev_req_bits_len;
  logic [TW-1:0] bdev_req_bits_tag;
  logic          bdev_data_valid, bdev_data_ready;
  logic [DW-1:0] bdev_data_bits_data;
  logic [TW-1:0] bdev_data_bits_tag;
  logic          bdev_resp_valid, bdev_resp_ready;
  logic [DW-1:0] bdev_resp_bits_data;
  logic [TW-1:0] bdev_resp_bits_tag;
  logic [SW-1:0] bdev_info_nsectors;

  always #5 clock = ~clock;

  block_device_requester #(
    .DATA_BITS  (DW),
    .SECTOR_BITS(SW),
    .TAG_BITS   (TW),
    .BEAT_BITS  (BB)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_offset          (cmd_offset),
    .cmd_len             (cmd_len),
    .cmd_tag             (cmd_tag),
    .wdata_valid         (wdata_valid),
    .wdata_ready         (wdata_ready),
    .wdata_bits          (wdata_bits),
    .rdata_valid         (rdata_valid),
    .rdata_ready         (rdata_ready),
    .rdata_bits          (rdata_bits),
    .done_valid          (done_valid),
    .done_tag            (done_tag),
    .done_error          (done_error),
    .busy                (busy),
    .bdev_req_valid      (bdev_req_valid),
    .bdev_req_ready      (bdev_req_ready),
    .bdev_req_bits_write (bdev_req_bits_write),
    .bdev_req_bits_offset(bdev_req_bits_offset),
    .bdev_req_bits_len   (bdev_req_bits_len),
    .bdev_req_bits_tag   (bdev_req_bits_tag),
    .bdev_data_valid     (bdev_data_valid),
    .bdev_data_ready     (bdev_data_ready),
    .bdev_data_bits_data (bdev_data_bits_data),
    .bdev_data_bits_tag  (bdev_data_bits_tag),
    .bdev_resp_valid     (bdev_resp_valid),
    .bdev_resp_ready     (bdev_resp_ready),
    .bdev_resp_bits_data (bdev_resp_bits_data),
    .bdev_resp_bits_tag  (bdev_resp_bits_tag),
    .bdev_info_nsectors  (bdev_info_nsectors)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Contents of the emulated disk: unique per sector, beat and command salt.
  function automatic logic [63:0] sector_word(input int unsigned sector, input int unsigned beat,
                                              input logic [15:0] salt);
    return {sector, salt, beat[15:0]};
  endfunction

  function automatic bit go(input int unsigned bp);
    return $urandom_range(99, 0) >= bp;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_offset = '0; cmd_len = '0; cmd_tag = '0;
    wdata_valid = 1'b0; wdata_bits = '0; rdata_ready = 1'b0;
    bdev_req_ready = 1'b0; bdev_data_ready = 1'b0;
    bdev_resp_valid = 1'b0; bdev_resp_bits_data = '0; bdev_resp_bits_tag = '0;
    bdev_info_nsectors = 32'd16;
  endtask

  task automatic apply_reset(input string name);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check_eq({name, ".rst_busy"}, longint'(busy), 0);
    check_eq({name, ".rst_cmd_ready"}, longint'(cmd_ready), 0);
    check_eq({name, ".rst_outs"}, longint'({bdev_req_valid, done_valid, rdata_valid,
                                            bdev_data_valid, wdata_ready, bdev_resp_ready}), 0);
    check_eq({name, ".rst_bits"}, longint'(bdev_req_bits_offset | bdev_req_bits_len), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq({name, ".post_rst_ready"}, longint'(cmd_ready), 1);
  endtask

  // Runs one command to completion (or aborts after abort_after cycles).
  // Device model modes: 0 await request, 1 send read beats, 2 take write beats,
  // 3 send write response, 4 finished.
  task automatic run_cmd(input string name, input bit wr, input int unsigned off,
                         input int unsigned len, input bit tg, input int unsigned nsec,
                         input int flip_idx, input int unsigned bp, input int abort_after,
                         input int lat_exact, input int lat_max);
    bit range_err, exp_req, exp_err, prev_hold, done_err_v;
    int nbeats, nresp, budget, widx, resp_idx, dev_rx, dev_left, dev_mode;
    int req_seen, done_cnt, acc_iter, done_iter, stab_err, cross_err, bad;
    logic [15:0]   salt;
    logic [63:0]   wq[$];
    logic [63:0]   got[$];
    logic [TW-1:0] done_tag_v, dev_tag, prev_tag, req_tag;
    logic [SW-1:0] dev_off, prev_off, prev_len, req_off, req_len;
    logic          prev_w, req_w;

    range_err = (len != 0) && (off + len > nsec);
    exp_req   = (len != 0) && !range_err;
    nbeats    = exp_req ? int'(len) * 64 : 0;
    nresp     = !exp_req ? 0 : (wr ? 1 : nbeats);
    exp_err   = range_err || (flip_idx >= 0 && flip_idx < nresp);
    salt      = 16'($urandom);
    wq.delete();
    got.delete();
    if (wr) for (int i = 0; i < nbeats; i++) wq.push_back({$urandom, $urandom});
    widx = 0; resp_idx = 0; dev_rx = 0; dev_left = 0; dev_mode = 0;
    req_seen = 0; done_cnt = 0; acc_iter = -1; done_iter = -1;
    stab_err = 0; cross_err = 0; bad = 0; prev_hold = 1'b0; done_err_v = 1'b0;
    done_tag_v = '0; dev_tag = '0; prev_tag = '0; req_tag = '0;
    dev_off = '0; prev_off = '0; prev_len = '0; req_off = '0; req_len = '0;
    prev_w = 1'b0; req_w = 1'b0;
    budget = int'(len) * 64 * 16 + 100;

    for (int it = 0; it < budget; it++) begin
      @(negedge clock);
      cmd_valid  = (acc_iter < 0);
      cmd_write  = wr;
      cmd_offset = off;
      cmd_len    = len;
      cmd_tag    = tg;
      bdev_info_nsectors = nsec;
      wdata_valid     = (widx < wq.size()) && go(bp);
      wdata_bits      = (widx < wq.size()) ? wq[widx] : '0;
      rdata_ready     = go(bp);
      bdev_req_ready  = go(bp);
      bdev_data_ready = go(bp);
      bdev_resp_valid = (dev_mode == 1 || dev_mode == 3) && go(bp);
      bdev_resp_bits_data = (dev_mode == 1) ?
          sector_word(dev_off + unsigned'(resp_idx / 64), unsigned'(resp_idx % 64), salt) :
          {$urandom, $urandom};
      bdev_resp_bits_tag = (flip_idx == resp_idx) ? ~dev_tag : dev_tag;
      #1;
      if (prev_hold && (!bdev_req_valid || bdev_req_bits_write != prev_w ||
          bdev_req_bits_offset != prev_off || bdev_req_bits_len != prev_len ||
          bdev_req_bits_tag != prev_tag)) stab_err++;
      prev_hold = bdev_req_valid && !bdev_req_ready;
      prev_w = bdev_req_bits_write; prev_off = bdev_req_bits_offset;
      prev_len = bdev_req_bits_len; prev_tag = bdev_req_bits_tag;
      if (cmd_valid && cmd_ready) acc_iter = it;
      if (bdev_data_valid && bdev_data_ready) begin
        if (dev_mode != 2 || dev_rx >= wq.size() || bdev_data_bits_data != wq[dev_rx] ||
            bdev_data_bits_tag != dev_tag) bad++;
        dev_rx++;
        if (dev_mode == 2 && dev_rx == dev_left) dev_mode = 3;
      end
      if (wdata_valid && wdata_ready) widx++;
      if (bdev_resp_valid && bdev_resp_ready) begin
        resp_idx++;
        if (dev_mode == 3 || resp_idx == dev_left) dev_mode = 4;
      end
      if (rdata_valid && rdata_ready) got.push_back(rdata_bits);
      if ((rdata_valid && wr) || (bdev_data_valid && !wr)) cross_err++;
      if (bdev_req_valid && bdev_req_ready) begin
        req_seen++;
        req_w = bdev_req_bits_write; req_off = bdev_req_bits_offset;
        req_len = bdev_req_bits_len; req_tag = bdev_req_bits_tag;
        dev_mode = bdev_req_bits_write ? 2 : 1;
        dev_off  = bdev_req_bits_offset;
        dev_tag  = bdev_req_bits_tag;
        dev_left = int'(bdev_req_bits_len) * 64;
      end
      if (done_valid) begin
        done_cnt++;
        if (done_iter < 0) begin
          done_iter = it; done_err_v = done_error; done_tag_v = done_tag;
        end
      end
      if (abort_after > 0 && it == abort_after) break;
      if (done_iter >= 0 && it >= done_iter + 3) break;
    end

    if (abort_after > 0) begin
      check_eq({name, ".no_done_before_abort"}, longint'(done_cnt), 0);
      check_eq({name, ".busy_at_abort"}, longint'(busy), 1);
      return;
    end
    check_eq({name, ".done_seen"}, longint'(done_iter >= 0), 1);
    check_eq({name, ".done_once"}, longint'(done_cnt), 1);
    check_eq({name, ".done_error"}, longint'(done_err_v), longint'(exp_err));
    check_eq({name, ".done_tag"}, longint'(done_tag_v), longint'(tg));
    check_eq({name, ".req_count"}, longint'(req_seen), longint'(exp_req));
    if (exp_req) begin
      check_eq({name, ".req_write"}, longint'(req_w), longint'(wr));
      check_eq({name, ".req_offset"}, longint'(req_off), longint'(off));
      check_eq({name, ".req_len"}, longint'(req_len), longint'(len));
      check_eq({name, ".req_tag"}, longint'(req_tag), longint'(tg));
    end
    for (int i = 0; i < got.size(); i++)
      if (got[i] != sector_word(off + unsigned'(i / 64), unsigned'(i % 64), salt)) bad++;
    check_eq({name, ".beats"}, longint'(wr ? dev_rx : got.size()), longint'(nbeats));
    check_eq({name, ".data_bad"}, longint'(bad), 0);
    check_eq({name, ".req_stable"}, longint'(stab_err), 0);
    check_eq({name, ".wrong_dir"}, longint'(cross_err), 0);
    check_eq({name, ".idle_after"}, longint'(busy), 0);
    if (lat_exact >= 0) check_eq({name, ".latency"}, longint'(done_iter - acc_iter), lat_exact);
    if (lat_max > 0)
      check_eq({name, ".latency_bound"}, longint'(done_iter - acc_iter <= lat_max), 1);
  endtask

  initial begin
    int unsigned nsec, off, len;
    bit wr;
    int flip;
    idle_inputs();
    reset = 1'b0;
    apply_reset("init");

    // Accept -> done spans CHECK, REQ, 64 beats and the DONE cycle itself.
    run_cmd("rd4", 1'b0, 4, 1, 1'b1, 16, -1, 0, 0, 67, 0);
    run_cmd("wr0", 1'b1, 0, 2, 1'b0, 16, -1, 0, 0, -1, 0);
    run_cmd("range", 1'b0, 15, 2, 1'b1, 16, -1, 0, 0, -1, 2);
    run_cmd("len0", 1'b1, 3, 0, 1'b0, 16, -1, 0, 0, -1, 2);
    run_cmd("tagflip", 1'b0, 4, 1, 1'b0, 16, 10, 0, 0, -1, 0);
    run_cmd("wr_tagflip", 1'b1, 2, 1, 1'b1, 16, 0, 20, 0, -1, 0);
    run_cmd("abort", 1'b0, 0, 2, 1'b1, 16, -1, 0, 30, -1, 0);
    // The device model is local to each command, so the next run starts fresh.
    apply_reset("midop");
    run_cmd("after_rst", 1'b0, 1, 1, 1'b0, 16, -1, 30, 0, -1, 0);

    for (int k = 0; k < 24; k++) begin
      nsec = $urandom_range(20, 4);
      off  = $urandom_range(nsec, 0);
      len  = $urandom_range(3, 0);
      wr   = 1'($urandom);
      flip = -1;
      if (len > 0 && $urandom_range(3, 0) == 0)
        flip = wr ? 0 : int'($urandom_range(len * 64 - 1, 0));
      run_cmd($sformatf("rnd%0d", k), wr, off, len, 1'($urandom), nsec, flip,
              $urandom_range(50, 0), 0, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
